// File: rtl/tow_round_ctrl.sv
// tow_round_ctrl: tug-of-war round sequencer (random arm delay, button arbitration,
// false-start penalty, rope position and game-over detection).
// Ports:
//   clk, rst              500 Hz clock, synchronous active-high reset
//   slowen                one-clk tick enable from Div256
//   rand_val[7:0]         LFSR value, sampled only in CLEAR
//   pbl, pbr              synchronised left/right button pulses
//   clr                   centre "go" LED, buttons live while high
//   winrnd, right, tie    round-decided pulse, winner (1 = right), tie pulse
//   pos[2:0]              rope position 0..6 (3 = centre)
//   game_over             level, set once pos reaches 0 or 6
module tow_round_ctrl #(
    parameter int WAIT_MIN   = 4,
    parameter int RAND_W     = 4,
    parameter int HOLD_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       slowen,
    input  logic [7:0] rand_val,
    input  logic       pbl,
    input  logic       pbr,
    output logic       clr,
    output logic       winrnd,
    output logic       right,
    output logic       tie,
    output logic [2:0] pos,
    output logic       game_over
);
    localparam int CW = $clog2(WAIT_MIN + 2 ** RAND_W + HOLD_TICKS + 1);

    typedef enum logic [2:0] {CLEAR, WAIT, ARMED, RESULT, HOLD, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] delay;
    logic          go_r;
    logic          go_l;
    logic          at_end;
    logic          unused_rand;

    assign unused_rand = ^rand_val[7:RAND_W];
    // In WAIT a press is a false start, so the presser's opponent wins.
    assign go_r   = (state == ARMED) ? pbr & ~pbl : pbl & ~pbr;
    assign go_l   = (state == ARMED) ? pbl & ~pbr : pbr & ~pbl;
    assign at_end = (pos == 3'd0) || (pos == 3'd6);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            pos       <= 3'd3;
            clr       <= 1'b0;
            winrnd    <= 1'b0;
            right     <= 1'b0;
            tie       <= 1'b0;
            game_over <= 1'b0;
            cnt       <= '0;
            delay     <= '0;
        end else begin
            winrnd <= 1'b0;
            tie    <= 1'b0;
            case (state)
                CLEAR: begin
                    delay <= CW'(WAIT_MIN) + CW'(rand_val[RAND_W-1:0]);
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT, ARMED: begin
                    // A press beats arming when both happen in the same clk.
                    if (pbl | pbr) begin
                        state  <= RESULT;
                        winrnd <= 1'b1;
                        tie    <= pbl & pbr;
                        right  <= go_r;
                        clr    <= 1'b0;
                        pos    <= pos + 3'(go_r) - 3'(go_l);
                    end else if (state == WAIT) begin
                        if (cnt == delay) begin
                            state <= ARMED;
                            clr   <= 1'b1;
                        end else if (slowen) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RESULT: begin
                    cnt   <= '0;
                    state <= HOLD;
                end
                HOLD: begin
                    if (cnt == CW'(HOLD_TICKS)) begin
                        state     <= at_end ? DONE : CLEAR;
                        game_over <= at_end;
                    end else if (slowen) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: state <= DONE;
                default: state <= CLEAR;
            endcase
        end
    end
endmodule
